ssd1331_spi_decoder: RTL and testbench
======================================

# ssd1331_spi_decoder

Receive-side model of the SSD1331 4-wire SPI link. It oversamples CS/SCK/MOSI/DC on the system clock, assembles MSB-first bytes, parses the command subset the OLED driver emits (display on/off, remap, column/row window) and turns data bytes into addressed 8-bit pixel writes for a 96x64 frame buffer. It sits opposite the OLED interface, in simulation benches and in on-FPGA loopback/mirror displays.

## Interface
- NUM_COL, 96, columns in frame buffer
- NUM_ROW, 64, rows in frame buffer
- N_COLOR_BITS, 8, pixel width (must equal 8; one byte per pixel)
- ADDR_W, 13, frame-buffer address width (ceil log2(NUM_COL*NUM_ROW))

Ports:
- i_CLK  in  1  system clock (100 MHz); one clock, every flop on its rising edge
- i_RST  in  1  reset, synchronous, active-high
- i_CS  in  1  SPI chip select, active low, asynchronous to i_CLK
- i_SCK  in  1  SPI clock, idle low, MOSI sampled on rising edge
- i_MOSI  in  1  serial data, MSB first
- i_DC  in  1  0 = command byte, 1 = data byte; sampled with bit 0
- i_RES  in  1  OLED reset pin, active low, asynchronous
- o_BYTE_VALID  out  1  one-cycle pulse per received byte
- o_BYTE  out  8  received byte, valid with o_BYTE_VALID
- o_BYTE_DC  out  1  DC of that byte
- o_PIX_WE  out  1  one-cycle pixel write strobe
- o_PIX_ADDR  out  ADDR_W  row*NUM_COL + col
- o_PIX_DATA  out  8  pixel colour
- o_DISPLAY_ON  out  1  set by 0xAF, cleared by 0xAE
- o_REMAP  out  8  last 0xA0 argument
- o_ERR  out  1  one-cycle pulse on protocol error

## Operation
- Input sync: i_CS, i_SCK, i_MOSI, i_DC, i_RES each through 2 flops; SCK rise = synced SCK high and previous synced SCK low.
- Shifter: on SCK rise with synced CS low, shift MOSI into LSB, bit counter 0..7; at count 7 the byte completes, DC captured at same edge, counter returns to 0.
- Synced CS high: bit counter cleared; if counter != 0, partial byte discarded and o_ERR pulses.
- Parser FSM: P_CMD, P_COL_A, P_COL_B, P_ROW_A, P_ROW_B, P_REMAP.
  - P_CMD, command 0x15 -> P_COL_A; 0x75 -> P_ROW_A; 0xA0 -> P_REMAP; 0xAF sets o_DISPLAY_ON; 0xAE clears it; any other command ignored (single byte), stay.
  - P_COL_A -> P_COL_B latching start; P_COL_B latches end, applies window, -> P_CMD. Row states identical.
  - P_REMAP: latch o_REMAP, -> P_CMD.
  - Data byte (DC=1) in any arg state: o_ERR pulse, pending command abandoned, FSM -> P_CMD, byte still processed as pixel.
- Window apply: accepted only if start <= end and end < NUM_COL (col) / NUM_ROW (row); else o_ERR, old window and cursor kept. Accepted: window updated, that axis's cursor = start.
- Pixel write (data byte): o_PIX_ADDR = cur_row*NUM_COL + cur_col, o_PIX_DATA = byte. Then if cur_col == col_end: cur_col = col_start, cur_row = (cur_row == row_end) ? row_start : cur_row+1; else cur_col+1.
- Reset (i_RST, or synced i_RES low): col window 0..NUM_COL-1, row window 0..NUM_ROW-1, cursors 0, FSM P_CMD, bit counter 0, o_DISPLAY_ON 0, o_REMAP 8'h40, all strobes 0, o_BYTE 0, o_BYTE_DC 0, o_PIX_ADDR 0, o_PIX_DATA 0. Applies mid-byte or mid-command; no o_ERR.

## Timing
- Requires i_CLK >= 4x SCK frequency with SCK high and low each >= 2 i_CLK periods (SCK at 5 MHz gives 20x).
- o_BYTE_VALID/o_BYTE/o_BYTE_DC registered 1 cycle after the i_CLK cycle detecting the 8th SCK rise (≈3-4 i_CLK after the pin edge).
- o_PIX_WE, window updates, o_DISPLAY_ON/o_REMAP changes, o_ERR: same cycle as o_BYTE_VALID (decode from shifter output, all registered together).
- Arithmetic: address multiply uses NUM_COL constant; max address NUM_COL*NUM_ROW-1 = 6143 fits ADDR_W.
- Back-to-back bytes with no CS deassert are supported; CS may stay low across commands.
- o_PIX_WE and o_BYTE_VALID never assert more than once per byte; no byte-level backpressure.

## Test plan
- Reset then bytes AF,A0,40 (DC=0) -> three o_BYTE_VALID pulses, o_DISPLAY_ON=1, o_REMAP=8'h40, no o_PIX_WE, no o_ERR.
- Cmds 15,05,07,75,02,03 then 8 data bytes 00..07 -> writes at addrs 197,198,199,293,294,295,197,198 (wrap to window start).
- After reset, 6144 data bytes -> last write addr 6143, next byte writes addr 0.
- Cmds 15,10,05 -> o_ERR pulse, next data byte still writes addr 0; cmds 15,00,60 -> o_ERR (end 96 out of range).
- CS raised after 5 bits, then full byte AE -> one o_ERR, then o_DISPLAY_ON=0, o_BYTE=8'hAE.
- i_RES low 3 SCK periods mid-byte after window 15,05,07 -> window restored 0..95, cursor 0, o_REMAP=8'h40, next data writes addr 0.

Source files
------------

// File: rtl/ssd1331_spi_decoder.sv
// ssd1331_spi_decoder
// Receive side of the SSD1331 4-wire SPI link. All SPI pins are oversampled
// on i_CLK, bytes are assembled MSB first, command bytes drive a small parser
// (display on/off, remap, column/row window) and data bytes become addressed
// pixel writes into a NUM_COL x NUM_ROW frame buffer.
//
// Ports
//   i_CLK        system clock, all flops on its rising edge
//   i_RST        synchronous active-high reset
//   i_CS         SPI chip select, active low (asynchronous)
//   i_SCK        SPI clock, idle low, MOSI sampled on its rising edge
//   i_MOSI       serial data, MSB first
//   i_DC         0 = command byte, 1 = data byte (taken with bit 0)
//   i_RES        OLED reset pin, active low (asynchronous)
//   o_BYTE_VALID one-cycle pulse per received byte
//   o_BYTE       received byte
//   o_BYTE_DC    DC level of that byte
//   o_PIX_WE     one-cycle pixel write strobe
//   o_PIX_ADDR   row*NUM_COL + col of the pixel written
//   o_PIX_DATA   pixel colour
//   o_DISPLAY_ON set by 0xAF, cleared by 0xAE
//   o_REMAP      last 0xA0 argument
//   o_ERR        one-cycle pulse on a protocol error
module ssd1331_spi_decoder #(
    parameter int NUM_COL      = 96,
    parameter int NUM_ROW      = 64,
    parameter int N_COLOR_BITS = 8,
    parameter int ADDR_W       = 13
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_CS,
    input  logic                    i_SCK,
    input  logic                    i_MOSI,
    input  logic                    i_DC,
    input  logic                    i_RES,
    output logic                    o_BYTE_VALID,
    output logic [7:0]              o_BYTE,
    output logic                    o_BYTE_DC,
    output logic                    o_PIX_WE,
    output logic [ADDR_W-1:0]       o_PIX_ADDR,
    output logic [N_COLOR_BITS-1:0] o_PIX_DATA,
    output logic                    o_DISPLAY_ON,
    output logic [7:0]              o_REMAP,
    output logic                    o_ERR
);

    localparam int COL_W = $clog2(NUM_COL);
    localparam int ROW_W = $clog2(NUM_ROW);

    localparam logic [7:0]        COL_LIMIT  = 8'(NUM_COL);
    localparam logic [7:0]        ROW_LIMIT  = 8'(NUM_ROW);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(NUM_COL - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(NUM_ROW - 1);
    localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(NUM_COL);

    localparam logic [7:0] CMD_COL_ADDR = 8'h15;
    localparam logic [7:0] CMD_ROW_ADDR = 8'h75;
    localparam logic [7:0] CMD_REMAP    = 8'hA0;
    localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
    localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
    localparam logic [7:0] REMAP_RESET  = 8'h40;

    typedef enum logic [2:0] {
        P_CMD   = 3'd0,
        P_COL_A = 3'd1,
        P_COL_B = 3'd2,
        P_ROW_A = 3'd3,
        P_ROW_B = 3'd4,
        P_REMAP = 3'd5
    } parser_state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    logic cs_meta_r,   cs_sync_r;
    logic sck_meta_r,  sck_sync_r, sck_prev_r;
    logic mosi_meta_r, mosi_sync_r;
    logic dc_meta_r,   dc_sync_r;
    logic res_meta_r,  res_sync_r;

    // Two-flop synchronisers for every SPI pin plus SCK edge history.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            sck_meta_r  <= 1'b0;
            sck_sync_r  <= 1'b0;
            sck_prev_r  <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            dc_meta_r   <= 1'b0;
            dc_sync_r   <= 1'b0;
            res_meta_r  <= 1'b1;
            res_sync_r  <= 1'b1;
        end else begin
            cs_meta_r   <= i_CS;
            cs_sync_r   <= cs_meta_r;
            sck_meta_r  <= i_SCK;
            sck_sync_r  <= sck_meta_r;
            sck_prev_r  <= sck_sync_r;
            mosi_meta_r <= i_MOSI;
            mosi_sync_r <= mosi_meta_r;
            dc_meta_r   <= i_DC;
            dc_sync_r   <= dc_meta_r;
            res_meta_r  <= i_RES;
            res_sync_r  <= res_meta_r;
        end
    end

    // The OLED reset pin clears everything downstream of the synchronisers,
    // exactly like i_RST, but never raises o_ERR.
    logic rst_s;
    logic sck_rise_s;
    assign rst_s      = i_RST | ~res_sync_r;
    assign sck_rise_s = sck_sync_r & ~sck_prev_r;

    // ------------------------------------------------------------------
    // Byte assembler
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_r;
    logic [6:0] shift_r;
    logic [7:0] byte_s;
    logic       byte_done_s;
    logic       cs_err_s;

    // Completed byte is the seven stored bits plus the bit on the wire now,
    // so decode happens in the same cycle the 8th rising edge is detected.
    assign byte_s      = {shift_r, mosi_sync_r};
    assign byte_done_s = sck_rise_s & ~cs_sync_r & (bit_cnt_r == 3'd7);
    assign cs_err_s    = cs_sync_r & (bit_cnt_r != 3'd0);

    // Bit counter and shift register; CS high re-frames to a byte boundary.
    always_ff @(posedge i_CLK) begin
        if (rst_s) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 7'd0;
        end else if (cs_sync_r) begin
            bit_cnt_r <= 3'd0;
        end else if (sck_rise_s) begin
            shift_r   <= byte_s[6:0];
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Parser and pixel addressing
    // ------------------------------------------------------------------
    parser_state_t       state_r, state_nxt;
    logic [7:0]          arg_start_r, arg_start_nxt;
    logic [COL_W-1:0]    col_start_r, col_start_nxt;
    logic [COL_W-1:0]    col_end_r,   col_end_nxt;
    logic [ROW_W-1:0]    row_start_r, row_start_nxt;
    logic [ROW_W-1:0]    row_end_r,   row_end_nxt;
    logic [COL_W-1:0]    cur_col_r,   cur_col_nxt;
    logic [ROW_W-1:0]    cur_row_r,   cur_row_nxt;
    logic                display_on_r, display_on_nxt;
    logic [7:0]          remap_r,      remap_nxt;
    logic                pix_we_r,     pix_we_nxt;
    logic [ADDR_W-1:0]   pix_addr_r,   pix_addr_nxt;
    logic [N_COLOR_BITS-1:0] pix_data_r, pix_data_nxt;
    logic                byte_valid_r;
    logic [7:0]          byte_r;
    logic                byte_dc_r;
    logic                err_r;
    logic                parse_err_s;
    logic [ADDR_W-1:0]   pix_addr_s;

    assign pix_addr_s = ADDR_W'(cur_row_r) * COL_STRIDE + ADDR_W'(cur_col_r);

    // Parser next-state, window/cursor update and pixel write decode.
    always_comb begin
        state_nxt      = state_r;
        arg_start_nxt  = arg_start_r;
        col_start_nxt  = col_start_r;
        col_end_nxt    = col_end_r;
        row_start_nxt  = row_start_r;
        row_end_nxt    = row_end_r;
        cur_col_nxt    = cur_col_r;
        cur_row_nxt    = cur_row_r;
        display_on_nxt = display_on_r;
        remap_nxt      = remap_r;
        pix_we_nxt     = 1'b0;
        pix_addr_nxt   = pix_addr_r;
        pix_data_nxt   = pix_data_r;
        parse_err_s    = 1'b0;

        if (byte_done_s) begin
            if (dc_sync_r) begin
                // Data byte: always a pixel; it also abandons any pending
                // command that was still waiting for arguments.
                pix_we_nxt   = 1'b1;
                pix_addr_nxt = pix_addr_s;
                pix_data_nxt = N_COLOR_BITS'(byte_s);
                if (cur_col_r == col_end_r) begin
                    cur_col_nxt = col_start_r;
                    if (cur_row_r == row_end_r) begin
                        cur_row_nxt = row_start_r;
                    end else begin
                        cur_row_nxt = cur_row_r + ROW_W'(1);
                    end
                end else begin
                    cur_col_nxt = cur_col_r + COL_W'(1);
                end
                if (state_r != P_CMD) begin
                    parse_err_s = 1'b1;
                    state_nxt   = P_CMD;
                end else begin
                    state_nxt   = P_CMD;
                end
            end else begin
                case (state_r)
                    P_CMD: begin
                        case (byte_s)
                            CMD_COL_ADDR: state_nxt      = P_COL_A;
                            CMD_ROW_ADDR: state_nxt      = P_ROW_A;
                            CMD_REMAP:    state_nxt      = P_REMAP;
                            CMD_DISP_ON:  display_on_nxt = 1'b1;
                            CMD_DISP_OFF: display_on_nxt = 1'b0;
                            default:      state_nxt      = P_CMD;
                        endcase
                    end
                    P_COL_A: begin
                        arg_start_nxt = byte_s;
                        state_nxt     = P_COL_B;
                    end
                    P_COL_B: begin
                        // A rejected window leaves window and cursor intact.
                        if ((arg_start_r <= byte_s) && (byte_s < COL_LIMIT)) begin
                            col_start_nxt = arg_start_r[COL_W-1:0];
                            col_end_nxt   = byte_s[COL_W-1:0];
                            cur_col_nxt   = arg_start_r[COL_W-1:0];
                        end else begin
                            parse_err_s   = 1'b1;
                        end
                        state_nxt = P_CMD;
                    end
                    P_ROW_A: begin
                        arg_start_nxt = byte_s;
                        state_nxt     = P_ROW_B;
                    end
                    P_ROW_B: begin
                        if ((arg_start_r <= byte_s) && (byte_s < ROW_LIMIT)) begin
                            row_start_nxt = arg_start_r[ROW_W-1:0];
                            row_end_nxt   = byte_s[ROW_W-1:0];
                            cur_row_nxt   = arg_start_r[ROW_W-1:0];
                        end else begin
                            parse_err_s   = 1'b1;
                        end
                        state_nxt = P_CMD;
                    end
                    P_REMAP: begin
                        remap_nxt = byte_s;
                        state_nxt = P_CMD;
                    end
                    default: begin
                        state_nxt = P_CMD;
                    end
                endcase
            end
        end else begin
            state_nxt = state_r;
        end
    end

    // Parser state register.
    always_ff @(posedge i_CLK) begin
        if (rst_s) begin
            state_r <= P_CMD;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Window, cursor and output registers; one byte's effects land together.
    always_ff @(posedge i_CLK) begin
        if (rst_s) begin
            arg_start_r  <= 8'd0;
            col_start_r  <= '0;
            col_end_r    <= COL_LAST;
            row_start_r  <= '0;
            row_end_r    <= ROW_LAST;
            cur_col_r    <= '0;
            cur_row_r    <= '0;
            display_on_r <= 1'b0;
            remap_r      <= REMAP_RESET;
            pix_we_r     <= 1'b0;
            pix_addr_r   <= '0;
            pix_data_r   <= '0;
            byte_valid_r <= 1'b0;
            byte_r       <= 8'd0;
            byte_dc_r    <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            arg_start_r  <= arg_start_nxt;
            col_start_r  <= col_start_nxt;
            col_end_r    <= col_end_nxt;
            row_start_r  <= row_start_nxt;
            row_end_r    <= row_end_nxt;
            cur_col_r    <= cur_col_nxt;
            cur_row_r    <= cur_row_nxt;
            display_on_r <= display_on_nxt;
            remap_r      <= remap_nxt;
            pix_we_r     <= pix_we_nxt;
            pix_addr_r   <= pix_addr_nxt;
            pix_data_r   <= pix_data_nxt;
            byte_valid_r <= byte_done_s;
            if (byte_done_s) begin
                byte_r    <= byte_s;
                byte_dc_r <= dc_sync_r;
            end
            err_r        <= cs_err_s | parse_err_s;
        end
    end

    assign o_BYTE_VALID = byte_valid_r;
    assign o_BYTE       = byte_r;
    assign o_BYTE_DC    = byte_dc_r;
    assign o_PIX_WE     = pix_we_r;
    assign o_PIX_ADDR   = pix_addr_r;
    assign o_PIX_DATA   = pix_data_r;
    assign o_DISPLAY_ON = display_on_r;
    assign o_REMAP      = remap_r;
    assign o_ERR        = err_r;

endmodule

// File: tb/tb_ssd1331_spi_decoder.sv
// Self-checking bench for ssd1331_spi_decoder: directed scenarios followed by
// randomized SPI traffic, checked by a scoreboard against a reference model.
module tb_ssd1331_spi_decoder;

    localparam int NUM_COL = 96;
    localparam int NUM_ROW = 64;
    localparam int ADDR_W  = 13;
    localparam int HALF    = 3;   // i_CLK cycles per SCK half period

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cs, sck, mosi, dc, res;
    logic              o_byte_valid, o_byte_dc, o_pix_we, o_display_on, o_err;
    logic [7:0]        o_byte, o_pix_data, o_remap;
    logic [ADDR_W-1:0] o_pix_addr;

    ssd1331_spi_decoder #(
        .NUM_COL(NUM_COL), .NUM_ROW(NUM_ROW), .N_COLOR_BITS(8), .ADDR_W(ADDR_W)
    ) dut (
        .i_CLK(clk), .i_RST(rst), .i_CS(cs), .i_SCK(sck), .i_MOSI(mosi),
        .i_DC(dc), .i_RES(res),
        .o_BYTE_VALID(o_byte_valid), .o_BYTE(o_byte), .o_BYTE_DC(o_byte_dc),
        .o_PIX_WE(o_pix_we), .o_PIX_ADDR(o_pix_addr), .o_PIX_DATA(o_pix_data),
        .o_DISPLAY_ON(o_display_on), .o_REMAP(o_remap), .o_ERR(o_err)
    );

    typedef struct {
        logic [7:0]        b;
        logic              dc;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              err;
        logic              don;
        logic [7:0]        remap;
    } exp_t;

    exp_t exp_q[$];
    int   pix_log[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cs_err = 0;
    int   err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_cs, m_ce, m_rs, m_re, m_cc, m_cr, m_pend, m_remap;
    bit m_don;
    int m_args[$];

    task automatic model_reset();
        m_cs = 0; m_ce = NUM_COL - 1; m_rs = 0; m_re = NUM_ROW - 1;
        m_cc = 0; m_cr = 0; m_pend = 0; m_args.delete();
        m_don = 1'b0; m_remap = 'h40;
    endtask

    task automatic model_byte(input bit d, input logic [7:0] b);
        exp_t e;
        int   lim;
        e.b = b; e.dc = d; e.we = 1'b0; e.addr = '0; e.data = 8'd0; e.err = 1'b0;
        if (d) begin
            if (m_pend != 0) begin
                e.err = 1'b1; m_pend = 0; m_args.delete();
            end
            e.we = 1'b1; e.addr = ADDR_W'(m_cr * NUM_COL + m_cc); e.data = b;
            if (m_cc == m_ce) begin
                m_cc = m_cs;
                m_cr = (m_cr == m_re) ? m_rs : m_cr + 1;
            end else begin
                m_cc = m_cc + 1;
            end
        end else if (m_pend == 0) begin
            case (b)
                8'h15, 8'h75, 8'hA0: m_pend = int'(b);
                8'hAF: m_don = 1'b1;
                8'hAE: m_don = 1'b0;
                default: ;
            endcase
        end else begin
            m_args.push_back(int'(b));
            if (m_pend == 'hA0) begin
                m_remap = int'(b); m_pend = 0; m_args.delete();
            end else if (m_args.size() == 2) begin
                lim = (m_pend == 'h15) ? NUM_COL : NUM_ROW;
                if (m_args[0] <= m_args[1] && m_args[1] < lim) begin
                    if (m_pend == 'h15) begin
                        m_cs = m_args[0]; m_ce = m_args[1]; m_cc = m_args[0];
                    end else begin
                        m_rs = m_args[0]; m_re = m_args[1]; m_cr = m_args[0];
                    end
                end else begin
                    e.err = 1'b1;
                end
                m_pend = 0; m_args.delete();
            end
        end
        e.don = m_don; e.remap = 8'(m_remap);
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (o_err) err_cnt++;
        if (o_pix_we) pix_log.push_back(int'(o_pix_addr));
        if (o_byte_valid) begin
            chk("byte_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("byte", o_byte, mon_e.b);
                chk("byte_dc", o_byte_dc, mon_e.dc);
                chk("pix_we", o_pix_we, mon_e.we);
                chk("err", o_err, mon_e.err);
                chk("display_on", o_display_on, mon_e.don);
                chk("remap", o_remap, mon_e.remap);
                if (mon_e.we) begin
                    chk("pix_addr", o_pix_addr, mon_e.addr);
                    chk("pix_data", o_pix_data, mon_e.data);
                end
            end
        end else begin
            if (o_pix_we) chk("stray_pix_we", o_pix_we, o_byte_valid);
            if (o_err) begin
                chk("cs_err_expected", exp_cs_err > 0, 1'b1);
                if (exp_cs_err > 0) exp_cs_err--;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = b[7 - i];
            wait_clk(HALF);
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic send_byte(input bit d, input logic [7:0] b);
        model_byte(d, b);
        dc = d;
        send_bits(b, 8);
    endtask

    task automatic cs_cycle();
        cs = 1'b1; wait_clk(4);
        cs = 1'b0; wait_clk(4);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || exp_cs_err > 0) && n < 400) begin
            wait_clk(1); n++;
        end
        chk("drain_bytes", exp_q.size(), 0);
        chk("drain_cs_err", exp_cs_err, 0);
        wait_clk(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clk(4);
        chk("rst_byte_valid", o_byte_valid, 1'b0);
        chk("rst_byte", o_byte, 8'h00);
        chk("rst_byte_dc", o_byte_dc, 1'b0);
        chk("rst_pix_we", o_pix_we, 1'b0);
        chk("rst_pix_addr", o_pix_addr, 0);
        chk("rst_pix_data", o_pix_data, 8'h00);
        chk("rst_display_on", o_display_on, 1'b0);
        chk("rst_remap", o_remap, 8'h40);
        chk("rst_err", o_err, 1'b0);
        rst = 1'b0;
        model_reset();
        wait_clk(4);
    endtask

    function automatic int log_at(input int i);
        if (i < pix_log.size()) return pix_log[i];
        return -1;
    endfunction

    task automatic send_cmds(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(1'b0, a); send_byte(1'b0, b); send_byte(1'b0, c);
    endtask

    int exp_addr[8] = '{197, 198, 199, 293, 294, 295, 197, 198};
    int e0;

    initial begin
        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; dc = 1'b0; res = 1'b1;
        model_reset();
        do_reset();
        cs = 1'b0; wait_clk(4);

        // Display on, remap: three bytes, no pixel writes.
        pix_log.delete();
        send_cmds(8'hAF, 8'hA0, 8'h40);
        drain();
        chk("t1_display_on", o_display_on, 1'b1);
        chk("t1_remap", o_remap, 8'h40);
        chk("t1_no_pix", pix_log.size(), 0);

        // Window cols 5..7 rows 2..3, 8 data bytes wrap to window start.
        send_cmds(8'h15, 8'h05, 8'h07);
        send_cmds(8'h75, 8'h02, 8'h03);
        pix_log.delete();
        for (int i = 0; i < 8; i++) send_byte(1'b1, 8'(i));
        drain();
        for (int i = 0; i < 8; i++) chk($sformatf("t2_addr%0d", i), log_at(i), exp_addr[i]);

        // Bottom two rows: last write at 6143 then wrap to window start.
        send_cmds(8'h15, 8'h00, 8'h5F);
        send_cmds(8'h75, 8'h3E, 8'h3F);
        pix_log.delete();
        for (int i = 0; i < 193; i++) send_byte(1'b1, 8'($urandom_range(0, 255)));
        drain();
        chk("t3_first", log_at(0), 5952);
        chk("t3_last", log_at(191), 6143);
        chk("t3_wrap", log_at(192), 5952);

        // Bad windows: start > end, end out of range.
        do_reset();
        e0 = err_cnt;
        send_cmds(8'h15, 8'h10, 8'h05);
        pix_log.delete();
        send_byte(1'b1, 8'hAA);
        drain();
        chk("t4_err", err_cnt - e0, 1);
        chk("t4_addr0", log_at(0), 0);
        e0 = err_cnt;
        send_cmds(8'h15, 8'h00, 8'h60);
        drain();
        chk("t4_err_range", err_cnt - e0, 1);

        // Partial byte then CS high, then a full 0xAE.
        send_byte(1'b0, 8'hAF);
        drain();
        e0 = err_cnt;
        dc = 1'b0;
        send_bits(8'hFF, 5);
        exp_cs_err++;
        cs_cycle();
        send_byte(1'b0, 8'hAE);
        drain();
        chk("t5_err_once", err_cnt - e0, 1);
        chk("t5_display_off", o_display_on, 1'b0);
        chk("t5_byte", o_byte, 8'hAE);

        // OLED reset pin mid-byte restores defaults.
        send_cmds(8'h15, 8'h05, 8'h07);
        send_byte(1'b0, 8'hA0); send_byte(1'b0, 8'h12);
        drain();
        e0 = err_cnt;
        send_bits(8'h5A, 3);
        res = 1'b0;
        wait_clk(6 * HALF);
        res = 1'b1;
        model_reset();
        wait_clk(4);
        chk("t6_remap", o_remap, 8'h40);
        chk("t6_display_on", o_display_on, 1'b0);
        chk("t6_pix_addr", o_pix_addr, 0);
        cs_cycle();
        pix_log.delete();
        send_byte(1'b1, 8'h33);
        send_byte(1'b1, 8'h34);
        drain();
        chk("t6_no_err", err_cnt - e0, 0);
        chk("t6_addr0", log_at(0), 0);
        chk("t6_addr1", log_at(1), 1);

        // Randomized traffic.
        for (int op = 0; op < 120; op++) begin
            case ($urandom_range(0, 8))
                0: send_cmds(8'h15, 8'($urandom_range(0, 100)), 8'($urandom_range(0, 100)));
                1: send_cmds(8'h75, 8'($urandom_range(0, 70)), 8'($urandom_range(0, 70)));
                2: send_byte(1'b0, ($urandom_range(0, 1) == 0) ? 8'hAE : 8'hAF);
                3: begin send_byte(1'b0, 8'hA0); send_byte(1'b0, 8'($urandom_range(0, 255))); end
                4, 5: begin
                    int n;
                    n = $urandom_range(1, 8);
                    for (int k = 0; k < n; k++) send_byte(1'b1, 8'($urandom_range(0, 255)));
                end
                6: begin
                    drain();
                    dc = 1'($urandom_range(0, 1));
                    send_bits(8'($urandom_range(0, 255)), $urandom_range(1, 7));
                    exp_cs_err++;
                    cs_cycle();
                end
                7: begin
                    send_byte(1'b0, ($urandom_range(0, 1) == 0) ? 8'h15 : 8'h75);
                    send_byte(1'b1, 8'($urandom_range(0, 255)));
                end
                default: begin
                    send_byte(1'b0, 8'($urandom_range(0, 255)));
                    if ($urandom_range(0, 3) == 0) cs_cycle();
                end
            endcase
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
